axis_pkt_fifo: RTL and testbench
================================

AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 Parameter: DATA_WIDTH, 32, tdata width in bits; multiple of 8, 8..512.
REQ-002 Parameter: DEPTH, 16, storage words; power of two, >=4.
REQ-003 Parameter: PKT_MODE, 0, 0 = cut-through, 1 = store-and-forward.
REQ-004 axis_aclk  in  1  sole clock; all logic on the rising edge.
REQ-005 axis_areset  in  1  asynchronous, active-high reset.
REQ-006 s00_axis_tdata  in  DATA_WIDTH  input word.
REQ-007 s00_axis_tstrb  in  DATA_WIDTH/8  input byte strobes, stored with the word.
REQ-008 s00_axis_tlast  in  1  last word of the input packet.
REQ-009 s00_axis_tvalid  in  1  input word valid.
REQ-010 s00_axis_tready  out  1  block accepts the input word.
REQ-011 m00_axis_tdata  out  DATA_WIDTH  output word.
REQ-012 m00_axis_tstrb  out  DATA_WIDTH/8  output strobes.
REQ-013 m00_axis_tlast  out  1  last word of the output packet.
REQ-014 m00_axis_tvalid  out  1  output word valid.
REQ-015 m00_axis_tready  in  1  downstream accepts the output word.
REQ-016 fill_level  out  clog2(DEPTH)+1  stored words, committed plus uncommitted.
REQ-017 pkt_count  out  clog2(DEPTH)+1  complete packets (tlast written, not yet read).
REQ-018 pkt_drop  out  1  one-cycle pulse when an oversize packet is dropped.

Function
REQ-019 A transfer occurs on an edge where tvalid and tready are both high; no other edge moves data.
REQ-020 Storage: circular buffer of {tdata, tstrb, tlast}; read and write pointers are clog2(DEPTH)+1 bits, with the MSB used to tell full from empty.
REQ-021 Write FSM states: ACCEPT (reset state) and DISCARD.
REQ-022 In ACCEPT: s00_axis_tready = !full; accepted words are written at wr_ptr.
REQ-023 commit_ptr advances to wr_ptr+1 on an accepted tlast word; pkt_count increments on the same edge.
REQ-024 PKT_MODE=0: m00_axis_tvalid = (rd_ptr != wr_ptr); a word written at edge N is presentable from cycle N+1.
REQ-025 PKT_MODE=1: m00_axis_tvalid = (rd_ptr != commit_ptr); no word of a packet is presented before its tlast is written.
REQ-026 Output fields are driven combinationally from the entry at rd_ptr; there is no output register stage.
REQ-027 m00_axis_tvalid, once high, stays high with stable data until m00_axis_tready is high.
REQ-028 No bypass: a word arriving while the buffer is empty is not presented in the same cycle.
REQ-029 When full, a read and a write offered in the same cycle: the read completes, the write stalls (tready low), and the write is accepted on the next cycle.
REQ-030 When not full and not empty, a simultaneous read and write both complete; fill_level is unchanged.
REQ-031 pkt_count decrements on a read of a tlast word; a simultaneous increment and decrement leaves it unchanged.
REQ-032 Oversize (PKT_MODE=1 only): the current packet reaches DEPTH accepted words without tlast -> wr_ptr rewinds to commit_ptr, pkt_drop pulses, and the FSM enters DISCARD.
REQ-033 In DISCARD: s00_axis_tready = 1, words are not written, and an accepted tlast returns the FSM to ACCEPT.
REQ-034 In PKT_MODE=0 the FSM never leaves ACCEPT and pkt_drop stays 0.
REQ-035 fill_level = wr_ptr - rd_ptr, modulo 2^(clog2(DEPTH)+1).

Reset
REQ-036 On axis_areset: all pointers = 0, FSM = ACCEPT, fill_level = 0, pkt_count = 0, pkt_drop = 0, m00_axis_tvalid = 0, s00_axis_tready = 0.
REQ-037 Reset asserted mid-packet discards all stored and in-flight words; after release, the first accepted word is treated as the start of a new packet.
REQ-038 s00_axis_tready rises on the first edge after reset is released.
REQ-039 Storage contents are not reset.

Structure
REQ-040 Package axis_pkt_fifo_pkg holds the write-FSM state enum and the PKT_MODE encoding constants.
REQ-041 Storage is one sub-module, axis_fifo_ram: a single write port and an asynchronous read port.

Verification
REQ-042 PKT_MODE=0, DEPTH=16, oready=1: 16-word packet with data 0,1..9,10x6 and tlast on word 16 -> words out in order one cycle after each write, tlast on word 16, fill_level <= 1.
REQ-043 PKT_MODE=1: 5-word packet -> m00_axis_tvalid stays 0 until the edge after tlast is written, then 5 back-to-back words; pkt_count goes 1 -> 0.
REQ-044 PKT_MODE=1, DEPTH=16: 20-word packet followed by a 3-word packet -> pkt_drop pulses once, 0 words of the first packet appear, 3-word packet delivered intact.
REQ-045 m00_axis_tready=0 while 17 words are offered -> tready low after 16 words, fill_level = 16; with tready high and one read per cycle, word 17 is accepted on the cycle after the first read.
REQ-046 axis_areset pulsed after word 3 of a 6-word packet -> all outputs at reset values; next packet delivered intact with pkt_count = 1 after its tlast.

Source files
------------

// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and constants for the AXI-Stream packet FIFO.
//   wr_state_e           : write-side FSM state (accept words / discard oversize packet)
//   PKT_MODE_CUT_THROUGH : words are presentable as soon as they are written
//   PKT_MODE_STORE_FWD   : words are presentable only after their packet's tlast is written
package axis_pkt_fifo_pkg;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_e;

  localparam int unsigned PKT_MODE_CUT_THROUGH = 0;
  localparam int unsigned PKT_MODE_STORE_FWD   = 1;

endpackage

// File: rtl/axis_fifo_ram.sv
// Storage array for the packet FIFO: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write entry
//   raddr : read address
//   rdata : entry at raddr (combinational)
module axis_fifo_ram #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with optional store-and-forward packet mode.
// Entries hold {tdata, tstrb, tlast}. Pointers carry one extra MSB to tell
// full from empty. commit_ptr marks the end of the last complete packet; in
// store-and-forward mode only committed words are presented, and a packet
// that reaches DEPTH words without tlast is dropped and the rest of it
// discarded.
//   axis_aclk / axis_areset : clock, asynchronous active-high reset
//   s00_axis_*              : input stream (tdata, tstrb, tlast, tvalid, tready)
//   m00_axis_*              : output stream (tdata, tstrb, tlast, tvalid, tready)
//   fill_level              : stored words, committed plus uncommitted
//   pkt_count               : complete packets held (tlast written, not yet read)
//   pkt_drop                : one-cycle pulse per dropped oversize packet
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PKT_MODE   = PKT_MODE_CUT_THROUGH
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                      s00_axis_tlast,
  input  logic                      s00_axis_tvalid,
  output logic                      s00_axis_tready,
  output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                      m00_axis_tlast,
  output logic                      m00_axis_tvalid,
  input  logic                      m00_axis_tready,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic                      pkt_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned EW = DATA_WIDTH + SW + 1;

  localparam logic [PW-1:0] FULL_LVL  = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_FREE = PW'(DEPTH - 1);
  localparam bit            STORE_FWD = (PKT_MODE == PKT_MODE_STORE_FWD);

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] pkt_len;
  logic          tready_q, tready_d;
  logic          tvalid_q, tvalid_d;
  logic          drop_q, drop_d;
  logic          wr_fire, rd_fire, wr_en;
  logic [EW-1:0] wr_entry, rd_entry;

  assign wr_fire  = s00_axis_tvalid & tready_q;
  assign rd_fire  = tvalid_q & m00_axis_tready;
  assign wr_entry = {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast};
  // Words of the packet currently being written (not yet committed)
  assign pkt_len  = wr_ptr_q - commit_ptr_q;

  axis_fifo_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (axis_aclk),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_entry)
  );

  // Next-state: pointers, packet count, write FSM, and the flags registered from them
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    commit_ptr_d = commit_ptr_q;
    pkt_count_d  = pkt_count_q;
    state_d      = state_q;
    drop_d       = 1'b0;
    wr_en        = 1'b0;

    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (rd_entry[0]) begin
        pkt_count_d = pkt_count_d - PW'(1);
      end
    end

    if (wr_fire) begin
      unique case (state_q)
        ST_ACCEPT: begin
          wr_en = 1'b1;
          if (s00_axis_tlast) begin
            wr_ptr_d     = wr_ptr_q + PW'(1);
            commit_ptr_d = wr_ptr_q + PW'(1);
            pkt_count_d  = pkt_count_d + PW'(1);
          end else if (STORE_FWD && (pkt_len == LAST_FREE)) begin
            // Packet cannot ever fit: roll back to the last committed packet
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
            state_d  = ST_DISCARD;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end
        ST_DISCARD: begin
          if (s00_axis_tlast) begin
            state_d = ST_ACCEPT;
          end
        end
        default: state_d = ST_ACCEPT;
      endcase
    end

    fill_d   = wr_ptr_d - rd_ptr_d;
    // Registered handshake flags are computed from next-state pointers so they
    // always match the stored state in the following cycle.
    tready_d = (state_d == ST_DISCARD) || (fill_d != FULL_LVL);
    tvalid_d = STORE_FWD ? (rd_ptr_d != commit_ptr_d) : (rd_ptr_d != wr_ptr_d);
  end

  // State registers
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q      <= ST_ACCEPT;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      pkt_count_q  <= '0;
      fill_q       <= '0;
      tready_q     <= 1'b0;
      tvalid_q     <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      pkt_count_q  <= pkt_count_d;
      fill_q       <= fill_d;
      tready_q     <= tready_d;
      tvalid_q     <= tvalid_d;
      drop_q       <= drop_d;
    end
  end

  assign s00_axis_tready = tready_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = rd_entry[EW-1 -: DATA_WIDTH];
  assign m00_axis_tstrb  = rd_entry[SW:1];
  assign m00_axis_tlast  = rd_entry[0];
  assign fill_level      = fill_q;
  assign pkt_count       = pkt_count_q;
  assign pkt_drop        = drop_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Testbench for axis_pkt_fifo: one cut-through instance (index 0) and one
// store-and-forward instance (index 1), both DEPTH=16, DATA_WIDTH=32.
// A packet-level reference model predicts the output word stream, fill level,
// packet count, handshake flags and drop pulses; a monitor compares every cycle.
module tb_axis_pkt_fifo;

  localparam int DW    = 32;
  localparam int SW    = 4;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  typedef logic [DW+SW:0] word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata  [2];
  logic [SW-1:0] s_tstrb  [2];
  logic          s_tlast  [2];
  logic          s_tvalid [2];
  logic          s_tready [2];
  logic [DW-1:0] m_tdata  [2];
  logic [SW-1:0] m_tstrb  [2];
  logic          m_tlast  [2];
  logic          m_tvalid [2];
  logic          m_tready [2];
  logic [LW-1:0] fill     [2];
  logic [LW-1:0] pcnt     [2];
  logic          drop     [2];

  int    rdy_mode [2];     // 0 = hold low, 1 = hold high, 2 = random
  word_t exp_q    [2][$];  // words the DUT must present, in order
  word_t part_q   [2][$];  // store-and-forward: packet still being received
  bit    disc     [2];
  bit    drop_next[2];
  bit    stall    [2];
  word_t stall_w  [2];
  int    model_drops[2];
  int    obs_drops  [2];
  int    since_rst;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(0)) u_ct (
    .axis_aclk       (clk),
    .axis_areset     (rst),
    .s00_axis_tdata  (s_tdata[0]),
    .s00_axis_tstrb  (s_tstrb[0]),
    .s00_axis_tlast  (s_tlast[0]),
    .s00_axis_tvalid (s_tvalid[0]),
    .s00_axis_tready (s_tready[0]),
    .m00_axis_tdata  (m_tdata[0]),
    .m00_axis_tstrb  (m_tstrb[0]),
    .m00_axis_tlast  (m_tlast[0]),
    .m00_axis_tvalid (m_tvalid[0]),
    .m00_axis_tready (m_tready[0]),
    .fill_level      (fill[0]),
    .pkt_count       (pcnt[0]),
    .pkt_drop        (drop[0])
  );

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(1)) u_sf (
    .axis_aclk       (clk),
    .axis_areset     (rst),
    .s00_axis_tdata  (s_tdata[1]),
    .s00_axis_tstrb  (s_tstrb[1]),
    .s00_axis_tlast  (s_tlast[1]),
    .s00_axis_tvalid (s_tvalid[1]),
    .s00_axis_tready (s_tready[1]),
    .m00_axis_tdata  (m_tdata[1]),
    .m00_axis_tstrb  (m_tstrb[1]),
    .m00_axis_tlast  (m_tlast[1]),
    .m00_axis_tvalid (m_tvalid[1]),
    .m00_axis_tready (m_tready[1]),
    .fill_level      (fill[1]),
    .pkt_count       (pcnt[1]),
    .pkt_drop        (drop[1])
  );

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  // Posedges seen since reset was released
  always @(posedge clk) begin
    if (rst) since_rst <= 0;
    else     since_rst <= since_rst + 1;
  end

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        m_tready[i] = (rdy_mode[i] == 2) ? 1'($urandom_range(1)) : (rdy_mode[i] == 1);
    end
  end

  // Monitor + reference model, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_q[i].delete();
        part_q[i].delete();
        disc[i]      = 1'b0;
        drop_next[i] = 1'b0;
        stall[i]     = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int    fexp;
        int    pexp;
        word_t mw;
        word_t sw;
        word_t ew;
        fexp = exp_q[i].size() + part_q[i].size();
        pexp = 0;
        for (int k = 0; k < exp_q[i].size(); k++)
          if (exp_q[i][k][0]) pexp++;
        mw = {m_tdata[i], m_tstrb[i], m_tlast[i]};
        sw = {s_tdata[i], s_tstrb[i], s_tlast[i]};

        chk("fill_level", i, 64'(fill[i]), 64'(fexp));
        chk("pkt_count", i, 64'(pcnt[i]), 64'(pexp));
        chk("m_tvalid", i, 64'(m_tvalid[i]), 64'(exp_q[i].size() > 0));
        chk("s_tready", i, 64'(s_tready[i]),
            64'((since_rst > 0) && (disc[i] || fexp < DEPTH)));
        chk("pkt_drop", i, 64'(drop[i]), 64'(drop_next[i]));
        drop_next[i] = 1'b0;
        if (drop[i]) obs_drops[i]++;

        if (stall[i]) begin
          chk("hold_valid", i, 64'(m_tvalid[i]), 64'(1));
          chk("hold_word", i, 64'(mw), 64'(stall_w[i]));
        end
        stall[i]   = m_tvalid[i] && !m_tready[i];
        stall_w[i] = mw;

        // Output transfer at the coming edge
        if (m_tvalid[i] && m_tready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_word", i, 64'(mw), 64'(0));
          end else begin
            ew = exp_q[i].pop_front();
            chk("out_word", i, 64'(mw), 64'(ew));
          end
        end

        // Input transfer at the coming edge
        if (s_tvalid[i] && s_tready[i]) begin
          if (i == 0) begin
            exp_q[i].push_back(sw);
          end else if (disc[i]) begin
            if (s_tlast[i]) disc[i] = 1'b0;
          end else begin
            part_q[i].push_back(sw);
            if (s_tlast[i]) begin
              while (part_q[i].size() > 0) exp_q[i].push_back(part_q[i].pop_front());
            end else if (part_q[i].size() == DEPTH) begin
              part_q[i].delete();
              disc[i]      = 1'b1;
              drop_next[i] = 1'b1;
              model_drops[i]++;
            end
          end
        end
      end
    end
  end

  // Offer n words; pat 0 = data 0..9 then 10s, pat 1 = random. gap = idle percentage.
  task automatic send_words(input int i, input int n, input int pat, input bit last, input int gap);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int cyc;
      while (gap > 0 && $urandom_range(99) < gap) begin
        s_tvalid[i] = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid[i] = 1'b1;
      s_tdata[i]  = (pat == 0) ? DW'((k < 10) ? k : 10) : DW'($urandom);
      s_tstrb[i]  = (pat == 0) ? '1 : SW'($urandom);
      s_tlast[i]  = last && (k == n - 1);
      acc = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        acc = s_tready[i];
        @(posedge clk);
        #1;
        cyc++;
      end while (!acc && cyc < 2000);
      if (!acc) begin
        chk("send_timeout", i, 64'(0), 64'(1));
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        return;
      end
    end
    s_tvalid[i] = 1'b0;
    s_tlast[i]  = 1'b0;
  endtask

  task automatic drain();
    rdy_mode[0] = 1;
    rdy_mode[1] = 1;
    for (int c = 0; c < 3000 && (exp_q[0].size() + exp_q[1].size()) > 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", 0, 64'(exp_q[0].size() + exp_q[1].size()), 64'(0));
  endtask

  task automatic chk_reset_outputs(input int i);
    chk("rst_tvalid", i, 64'(m_tvalid[i]), 64'(0));
    chk("rst_tready", i, 64'(s_tready[i]), 64'(0));
    chk("rst_fill", i, 64'(fill[i]), 64'(0));
    chk("rst_pkt_count", i, 64'(pcnt[i]), 64'(0));
    chk("rst_pkt_drop", i, 64'(drop[i]), 64'(0));
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_tdata[i] = '0; s_tstrb[i] = '0; s_tlast[i] = 1'b0; s_tvalid[i] = 1'b0;
      m_tready[i] = 1'b0; rdy_mode[i] = 1; model_drops[i] = 0; obs_drops[i] = 0;
    end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst = 1'b0;

    // Cut-through: 16-word packet, always-ready sink
    send_words(0, 16, 0, 1'b1, 0);
    drain();

    // Cut-through: fill to 16 with sink stalled, 17th word waits for the first read
    rdy_mode[0] = 0;
    fork
      send_words(0, 17, 1, 1'b1, 0);
      begin
        repeat (30) @(posedge clk);
        #2;
        chk("full_level", 0, 64'(fill[0]), 64'(16));
        chk("full_tready", 0, 64'(s_tready[0]), 64'(0));
        rdy_mode[0] = 1;
      end
    join
    drain();

    // Cut-through: random packets, random gaps, random sink
    rdy_mode[0] = 2;
    for (int p = 0; p < 12; p++) send_words(0, $urandom_range(20, 1), 1, 1'b1, 30);
    drain();

    // Store-and-forward: 5-word packet
    send_words(1, 5, 0, 1'b1, 0);
    drain();

    // Store-and-forward: 20-word oversize packet then a 3-word packet
    send_words(1, 20, 1, 1'b1, 0);
    send_words(1, 3, 1, 1'b1, 0);
    drain();
    chk("drop_once", 1, 64'(obs_drops[1]), 64'(1));

    // Store-and-forward: random packets including oversize ones
    rdy_mode[1] = 2;
    for (int p = 0; p < 12; p++) send_words(1, $urandom_range(20, 1), 1, 1'b1, 30);
    drain();

    // Reset in the middle of a packet, then a fresh packet
    rdy_mode[0] = 0;
    send_words(0, 3, 1, 1'b0, 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_words(0, 6, 1, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_pkt_count", 0, 64'(pcnt[0]), 64'(1));
    drain();

    chk("drops_model", 1, 64'(obs_drops[1]), 64'(model_drops[1]));
    chk("drops_ct", 0, 64'(obs_drops[0]), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
